// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state type, command record and default geometry for the SRAM request controller
package sram_ctrl_pkg;

   localparam int CTRL_WIDTH = 8;
   localparam int CTRL_DEPTH = 32;
   localparam int CTRL_AW    = $clog2(CTRL_DEPTH);

   typedef enum logic {INIT, RUN} ctrl_state_t;

   typedef struct packed {
      logic                  wr;
      logic [CTRL_AW-1:0]    addr;
      logic [CTRL_WIDTH-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/sram_req_ctrl_if.sv
// sram_req_ctrl_if: host request/response channel of the SRAM request controller
interface sram_req_ctrl_if
   import sram_ctrl_pkg::*;
#(
   parameter int WIDTH = CTRL_WIDTH,
   parameter int DEPTH = CTRL_DEPTH
);

   localparam int AW = $clog2(DEPTH);

   logic             req_valid;
   logic             req_ready;
   logic             req_wr;
   logic [AW-1:0]    req_addr;
   logic [WIDTH-1:0] req_wdata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: clears the SRAM after reset, then runs host reads/writes through a registered command stage and a one-entry response slot
module sram_req_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WIDTH = CTRL_WIDTH,
   parameter int DEPTH = CTRL_DEPTH
)(
   input  logic             clk,
   input  logic             rst_n,
   sram_req_ctrl_if.slave   host,
   output logic             init_done,
   output logic             mem_en,
   output logic             mem_wr,
   output logic [DEPTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);

   localparam int AW = $clog2(DEPTH);

   ctrl_state_t      state_q, state_d;
   cmd_t             s1_q, s1_d;
   logic             s1_vld_q, s1_vld_d;
   logic             rsp_vld_q, rsp_vld_d;
   logic [WIDTH-1:0] rsp_q, rsp_d;
   logic             done_q, done_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic             stall, accept, capture, s1_read;

   // A read in s1 cannot land while the response slot is full and not being drained
   assign s1_read        = s1_vld_q && !s1_q.wr;
   assign stall          = s1_read && rsp_vld_q && !host.rsp_ready;
   assign capture        = s1_read && !(rsp_vld_q && !host.rsp_ready);
   assign host.req_ready = (state_q == RUN) && !stall;
   assign accept         = host.req_valid && host.req_ready;

   assign host.rsp_valid = rsp_vld_q;
   assign host.rsp_rdata = rsp_q;
   assign init_done      = done_q;
   assign mem_en         = s1_vld_q;
   assign mem_wr         = s1_q.wr;
   assign mem_addr       = {{(DEPTH-AW){1'b0}}, s1_q.addr};
   assign mem_wdata      = s1_q.wdata;

   // State register: every output-driving flop clears asynchronously so a reset drops any pending response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= INIT;
         cnt_q     <= '0;
         s1_q      <= '0;
         s1_vld_q  <= 1'b0;
         rsp_vld_q <= 1'b0;
         rsp_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s1_q      <= s1_d;
         s1_vld_q  <= s1_vld_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_q     <= rsp_d;
         done_q    <= done_d;
      end
   end

   // Next state: INIT streams zero writes over the array; RUN loads, holds or idles s1 and manages the response slot
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      s1_d     = s1_q;
      s1_vld_d = s1_vld_q;
      done_d   = done_q;
      if (state_q == INIT) begin
         s1_vld_d = 1'b1;
         s1_d     = '{wr: 1'b1, addr: cnt_q, wdata: '0};
         cnt_d    = cnt_q + 1'b1;
         state_d  = (cnt_q == AW'(DEPTH - 1)) ? RUN : INIT;
      end else begin
         done_d = 1'b1;
         if (accept) begin
            s1_vld_d = 1'b1;
            s1_d     = '{wr: host.req_wr, addr: host.req_addr, wdata: host.req_wdata};
         end else if (!stall) begin
            s1_vld_d = 1'b0;
            s1_d.wr  = 1'b0;
         end
      end
      rsp_vld_d = capture || (rsp_vld_q && !host.rsp_ready);
      rsp_d     = capture ? mem_rdata : rsp_q;
   end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed stimulus with a response scoreboard around the controller and a behavioural SRAM
module tb_sram_req_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             init_done, mem_en, mem_wr;
   logic [DEPTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata, mem_rdata;

   logic [WIDTH-1:0] mem [DEPTH];
   logic             poisoned = 1'b0;

   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   int               req_cyc = 0;
   int               npops = 0;
   logic [WIDTH-1:0] exp_q [$];
   int               pop_cyc [$];
   logic             pv = 1'b0;
   logic             pr = 1'b0;
   logic [AW+WIDTH:0] snap = '0;

   sram_req_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) host();

   sram_req_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .host      (host),
      .init_done (init_done),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: filled with a non-zero pattern first so the clear is observable; negedge write, gated read
   always @(negedge clk) begin
      poisoned <= 1'b1;
      if (!poisoned) for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hEE;
      else if (mem_en && mem_wr) mem[mem_addr[AW-1:0]] <= mem_wdata;
   end
   assign mem_rdata = (mem_en && !mem_wr) ? mem[mem_addr[AW-1:0]] : '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
      end
   endtask

   // Monitor: scoreboard pops on each response handshake, plus address and request-stability checks
   always @(negedge clk) begin
      if (rst_n) begin
         chk("mem_addr_upper", 64'(mem_addr[DEPTH-1:AW]), 64'd0);
         if (host.rsp_valid && host.rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got 0x%0h with no response outstanding", host.rsp_rdata);
            end else begin
               chk("rsp_data", 64'(host.rsp_rdata), 64'(exp_q[0]));
               void'(exp_q.pop_front());
            end
            pop_cyc.push_back(cyc);
         end
         if (pv && !pr)
            chk("req_stable", 64'({host.req_valid, host.req_wr, host.req_addr, host.req_wdata}), 64'({1'b1, snap}));
      end
      pv   <= host.req_valid;
      pr   <= host.req_ready;
      snap <= {host.req_wr, host.req_addr, host.req_wdata};
   end

   task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [WIDTH-1:0] data,
                       input logic push, input logic [WIDTH-1:0] want);
      logic rdy;
      int   n;
      rdy = 1'b0;
      n   = 0;
      host.req_valid = 1'b1;
      host.req_wr    = wr;
      host.req_addr  = addr;
      host.req_wdata = data;
      while (!rdy && n < 100) begin
         @(negedge clk);
         rdy     = host.req_ready;
         req_cyc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: addr %0d not accepted within %0d cycles", addr, n);
      end
      host.req_valid = 1'b0;
      if (rdy && push) exp_q.push_back(want);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_init();
      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("init_cmd", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'({1'b1, 1'b1, 32'(i), 8'h00}));
         chk("init_done_low", 64'(init_done), 64'd0);
         if (i < DEPTH - 1) chk("init_ready_low", 64'(host.req_ready), 64'd0);
      end
      @(posedge clk);
      @(negedge clk);
      chk("init_done_high", 64'(init_done), 64'd1);
      chk("idle_en", 64'(mem_en), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      host.req_valid = 1'b0;
      host.req_wr    = 1'b0;
      host.req_addr  = '0;
      host.req_wdata = '0;
      host.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({host.req_ready, host.rsp_valid, host.rsp_rdata, init_done,
                                mem_en, mem_wr, mem_addr, mem_wdata}), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_init();
      @(posedge clk);
      #1;
      send(1'b0, 5'd5, 8'h00, 1'b1, 8'h00);
      drain();
      pop_cyc.delete();
      send(1'b1, 5'd3, 8'hA5, 1'b0, 8'h00);
      send(1'b0, 5'd3, 8'h00, 1'b1, 8'hA5);
      drain();
      chk("rd_latency", 64'(pop_cyc.size() == 1 ? pop_cyc[0] - req_cyc : -1), 64'd2);
      send(1'b1, 5'd1, 8'h11, 1'b0, 8'h00);
      send(1'b1, 5'd2, 8'h22, 1'b0, 8'h00);
      send(1'b1, 5'd3, 8'h33, 1'b0, 8'h00);
      pop_cyc.delete();
      send(1'b0, 5'd1, 8'h00, 1'b1, 8'h11);
      send(1'b0, 5'd2, 8'h00, 1'b1, 8'h22);
      send(1'b0, 5'd3, 8'h00, 1'b1, 8'h33);
      drain();
      chk("stream_count", 64'(pop_cyc.size()), 64'd3);
      chk("stream_span", 64'(pop_cyc.size() == 3 ? pop_cyc[2] - pop_cyc[0] : -1), 64'd2);
      host.rsp_ready = 1'b0;
      send(1'b0, 5'd1, 8'h00, 1'b1, 8'h11);
      send(1'b0, 5'd2, 8'h00, 1'b1, 8'h22);
      fork
         send(1'b1, 5'd9, 8'h99, 1'b0, 8'h00);
         begin
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               chk("stall_ready", 64'(host.req_ready), 64'd0);
               chk("stall_hold", 64'({host.rsp_valid, host.rsp_rdata}), 64'({1'b1, 8'h11}));
            end
            @(posedge clk);
            #1 host.rsp_ready = 1'b1;
         end
      join
      send(1'b0, 5'd9, 8'h00, 1'b1, 8'h99);
      drain();
      send(1'b1, 5'd31, 8'h7F, 1'b0, 8'h00);
      send(1'b0, 5'd31, 8'h00, 1'b1, 8'h7F);
      @(negedge clk);
      chk("addr31_cmd", 64'({mem_en, mem_wr, mem_addr}), 64'({1'b1, 1'b0, 32'd31}));
      drain();
      host.rsp_ready = 1'b0;
      send(1'b0, 5'd31, 8'h00, 1'b0, 8'h00);
      send(1'b0, 5'd3, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      chk("pre_reset_stall", 64'({host.req_ready, host.rsp_valid}), 64'({1'b0, 1'b1}));
      npops = pop_cyc.size();
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 64'({host.req_ready, host.rsp_valid, host.rsp_rdata, init_done,
                                      mem_en, mem_wr, mem_addr, mem_wdata}), 64'd0);
      host.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_init();
      chk("no_stale_rsp", 64'(pop_cyc.size()), 64'(npops));
      chk("rsp_idle_after_init", 64'(host.rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      send(1'b0, 5'd3, 8'h00, 1'b1, 8'h00);
      send(1'b0, 5'd31, 8'h00, 1'b1, 8'h00);
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
